// File: rtl/tetris_drop_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tetris_drop_ctrl_if : game-side framebuffer row port (req/gnt, full rows).
// Rev 1.0
// ============================================================================
interface tetris_drop_ctrl_if;
  logic        fb_req;
  logic        fb_we;
  logic [3:0]  fb_addr;
  logic [31:0] fb_wdata;
  logic        fb_gnt;
  logic [31:0] fb_rdata;

  modport master (
    output fb_req, fb_we, fb_addr, fb_wdata,
    input  fb_gnt, fb_rdata
  );

  modport slave (
    input  fb_req, fb_we, fb_addr, fb_wdata,
    output fb_gnt, fb_rdata
  );
endinterface
`default_nettype wire

// File: rtl/tetris_drop_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tetris_drop_ctrl : single falling-cell sequencer on a 16x16 2-bit matrix.
// Full-row clear is built only when TETRIS_LINE_CLEAR_EN is defined. Rev 1.0
// ============================================================================
module tetris_drop_ctrl #(
  parameter logic [3:0] SPAWN_X     = 4'd4,
  parameter logic [1:0] PIECE_COLOR = 2'd3
) (
  input  wire                 clk,
  input  wire                 rst_n,
  input  wire                 start,
  input  wire                 drop_tick,
  input  wire                 btn_left,
  input  wire                 btn_right,
  tetris_drop_ctrl_if.master  fb,
  output logic [3:0]          piece_x,
  output logic [3:0]          piece_y,
  output logic [7:0]          lines,
  output logic                busy,
  output logic                game_over
);

  localparam logic [4:0] S_IDLE      = 5'd0;
  localparam logic [4:0] S_SPAWN_RD  = 5'd1;
  localparam logic [4:0] S_SPAWN_CHK = 5'd2;
  localparam logic [4:0] S_SPAWN_WR  = 5'd3;
  localparam logic [4:0] S_WAIT      = 5'd4;
  localparam logic [4:0] S_HM_RD     = 5'd5;
  localparam logic [4:0] S_HM_CHK    = 5'd6;
  localparam logic [4:0] S_HM_WR     = 5'd7;
  localparam logic [4:0] S_DROP_RD   = 5'd8;
  localparam logic [4:0] S_DROP_CHK  = 5'd9;
  localparam logic [4:0] S_DROP_RD2  = 5'd10;
  localparam logic [4:0] S_DROP_CAP  = 5'd11;
  localparam logic [4:0] S_DROP_ER   = 5'd12;
  localparam logic [4:0] S_DROP_DR   = 5'd13;
  localparam logic [4:0] S_LAND      = 5'd14;
  localparam logic [4:0] S_OVER      = 5'd21;
  localparam logic [4:0] S_OVR_CLR   = 5'd22;
`ifdef TETRIS_LINE_CLEAR_EN
  localparam logic [4:0] S_CLR_RD    = 5'd15;
  localparam logic [4:0] S_CLR_CHK   = 5'd16;
  localparam logic [4:0] S_SH_RD     = 5'd17;
  localparam logic [4:0] S_SH_CAP    = 5'd18;
  localparam logic [4:0] S_SH_WR     = 5'd19;
  localparam logic [4:0] S_SH_TOP    = 5'd20;
`endif

  logic [4:0]  r_state;
  logic [4:0]  w_state_nx;
  logic        r_gap;
  logic [3:0]  r_x;
  logic [3:0]  r_y;
  logic [3:0]  r_tx;
  logic [31:0] r_row;
  logic [31:0] r_below;
  logic [3:0]  r_cnt;
  logic        w_acc;
  logic        w_gnt;
  logic        w_go_left;
  logic        w_go_right;

  function automatic logic [31:0] f_put(input logic [31:0] row, input logic [3:0] x,
                                        input logic [1:0] v);
    logic [31:0] res;
    res = row;
    res[{x, 1'b0} +: 2] = v;
    return res;
  endfunction

  function automatic logic f_occ(input logic [31:0] row, input logic [3:0] x);
    return row[{x, 1'b0} +: 2] != 2'b00;
  endfunction

  // A grant only counts while we are actually requesting.
  assign w_gnt      = fb.fb_gnt & fb.fb_req;
  assign w_go_left  = btn_left & ~btn_right & (r_x != 4'd0);
  assign w_go_right = btn_right & ~btn_left & (r_x != 4'd15);
  assign piece_x    = r_x;
  assign piece_y    = r_y;

`ifdef TETRIS_LINE_CLEAR_EN
  logic [15:0] w_cell_occ;
  logic        w_row_full;
  logic [7:0]  r_lines;

  for (genvar gi = 0; gi < 16; gi++) begin : g_row_full
    assign w_cell_occ[gi] = |fb.fb_rdata[2*gi +: 2];
  end
  assign w_row_full = &w_cell_occ;
  assign lines      = r_lines;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lines <= 8'd0;
    else if (r_state == S_OVER && start)
      r_lines <= 8'd0;
    else if (r_state == S_SH_TOP && w_gnt && r_lines != 8'hFF)
      r_lines <= r_lines + 8'd1;
  end
`else
  assign lines = 8'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nx = S_SPAWN_RD;
      S_SPAWN_RD:  if (w_gnt) w_state_nx = S_SPAWN_CHK;
      S_SPAWN_CHK: w_state_nx = f_occ(fb.fb_rdata, SPAWN_X) ? S_OVER : S_SPAWN_WR;
      S_SPAWN_WR:  if (w_gnt) w_state_nx = S_WAIT;
      S_WAIT: begin
        if (drop_tick)                    w_state_nx = (r_y == 4'd0) ? S_LAND : S_DROP_RD;
        else if (w_go_left || w_go_right) w_state_nx = S_HM_RD;
      end
      S_HM_RD:     if (w_gnt) w_state_nx = S_HM_CHK;
      S_HM_CHK:    w_state_nx = f_occ(fb.fb_rdata, r_tx) ? S_WAIT : S_HM_WR;
      S_HM_WR:     if (w_gnt) w_state_nx = S_WAIT;
      S_DROP_RD:   if (w_gnt) w_state_nx = S_DROP_CHK;
      S_DROP_CHK:  w_state_nx = f_occ(fb.fb_rdata, r_x) ? S_LAND : S_DROP_RD2;
      S_DROP_RD2:  if (w_gnt) w_state_nx = S_DROP_CAP;
      S_DROP_CAP:  w_state_nx = S_DROP_ER;
      S_DROP_ER:   if (w_gnt) w_state_nx = S_DROP_DR;
      S_DROP_DR:   if (w_gnt) w_state_nx = S_WAIT;
`ifdef TETRIS_LINE_CLEAR_EN
      S_LAND:      w_state_nx = S_CLR_RD;
      S_CLR_RD:    if (w_gnt) w_state_nx = S_CLR_CHK;
      S_CLR_CHK: begin
        if (!w_row_full)        w_state_nx = S_SPAWN_RD;
        else if (r_y == 4'd15)  w_state_nx = S_SH_TOP;
        else                    w_state_nx = S_SH_RD;
      end
      S_SH_RD:     if (w_gnt) w_state_nx = S_SH_CAP;
      S_SH_CAP:    w_state_nx = S_SH_WR;
      S_SH_WR:     if (w_gnt) w_state_nx = (r_cnt == 4'd14) ? S_SH_TOP : S_SH_RD;
      S_SH_TOP:    if (w_gnt) w_state_nx = S_SPAWN_RD;
`else
      S_LAND:      w_state_nx = S_SPAWN_RD;
`endif
      S_OVER:      if (start) w_state_nx = S_OVR_CLR;
      S_OVR_CLR:   if (w_gnt && r_cnt == 4'd15) w_state_nx = S_SPAWN_RD;
      default:     w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc       = 1'b0;
    fb.fb_we    = 1'b0;
    fb.fb_addr  = 4'd0;
    fb.fb_wdata = 32'd0;
    busy        = 1'b1;
    game_over   = 1'b0;
    case (r_state)
      S_IDLE, S_WAIT: busy = 1'b0;
      S_OVER: begin
        busy      = 1'b0;
        game_over = 1'b1;
      end
      S_SPAWN_RD: begin
        w_acc      = 1'b1;
        fb.fb_addr = 4'd15;
      end
      S_SPAWN_WR: begin
        w_acc       = 1'b1;
        fb.fb_we    = 1'b1;
        fb.fb_addr  = 4'd15;
        fb.fb_wdata = f_put(r_row, SPAWN_X, PIECE_COLOR);
      end
      S_HM_RD, S_DROP_RD2: begin
        w_acc      = 1'b1;
        fb.fb_addr = r_y;
      end
      S_HM_WR: begin
        w_acc       = 1'b1;
        fb.fb_we    = 1'b1;
        fb.fb_addr  = r_y;
        fb.fb_wdata = f_put(f_put(r_row, r_x, 2'b00), r_tx, PIECE_COLOR);
      end
      S_DROP_RD: begin
        w_acc      = 1'b1;
        fb.fb_addr = r_y - 4'd1;
      end
      S_DROP_ER: begin
        w_acc       = 1'b1;
        fb.fb_we    = 1'b1;
        fb.fb_addr  = r_y;
        fb.fb_wdata = f_put(r_row, r_x, 2'b00);
      end
      S_DROP_DR: begin
        w_acc       = 1'b1;
        fb.fb_we    = 1'b1;
        fb.fb_addr  = r_y - 4'd1;
        fb.fb_wdata = f_put(r_below, r_x, PIECE_COLOR);
      end
`ifdef TETRIS_LINE_CLEAR_EN
      S_CLR_RD: begin
        w_acc      = 1'b1;
        fb.fb_addr = r_y;
      end
      S_SH_RD: begin
        w_acc      = 1'b1;
        fb.fb_addr = r_cnt + 4'd1;
      end
      S_SH_WR: begin
        w_acc       = 1'b1;
        fb.fb_we    = 1'b1;
        fb.fb_addr  = r_cnt;
        fb.fb_wdata = r_row;
      end
      S_SH_TOP: begin
        w_acc      = 1'b1;
        fb.fb_we   = 1'b1;
        fb.fb_addr = 4'd15;
      end
`endif
      S_OVR_CLR: begin
        w_acc      = 1'b1;
        fb.fb_we   = 1'b1;
        fb.fb_addr = r_cnt;
      end
      default: ;
    endcase
    // One idle cycle after every grant keeps back-to-back accesses distinct.
    fb.fb_req = w_acc & ~r_gap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap   <= 1'b0;
      r_x     <= SPAWN_X;
      r_y     <= 4'd15;
      r_tx    <= SPAWN_X;
      r_row   <= 32'd0;
      r_below <= 32'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_gap <= w_gnt;
      case (r_state)
        S_SPAWN_CHK, S_HM_CHK, S_DROP_CAP: r_row <= fb.fb_rdata;
        S_DROP_CHK: r_below <= fb.fb_rdata;
        S_SPAWN_WR: if (w_gnt) begin
          r_x <= SPAWN_X;
          r_y <= 4'd15;
        end
        S_WAIT: if (!drop_tick) begin
          if (w_go_left)       r_tx <= r_x - 4'd1;
          else if (w_go_right) r_tx <= r_x + 4'd1;
        end
        S_HM_WR:   if (w_gnt) r_x <= r_tx;
        S_DROP_DR: if (w_gnt) r_y <= r_y - 4'd1;
        S_OVER:    if (start) r_cnt <= 4'd0;
        S_OVR_CLR: if (w_gnt) r_cnt <= r_cnt + 4'd1;
`ifdef TETRIS_LINE_CLEAR_EN
        S_SH_CAP:  r_row <= fb.fb_rdata;
        S_CLR_CHK: r_cnt <= r_y;
        S_SH_WR:   if (w_gnt) r_cnt <= r_cnt + 4'd1;
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tetris_drop_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_tetris_drop_ctrl : random play against an abstract grid model of the game.
// Rev 1.0
// ============================================================================
module tb_tetris_drop_ctrl;
  localparam logic [3:0] C_SX = 4'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, drop_tick = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0] piece_x, piece_y;
  logic [7:0] lines;
  logic       busy, game_over;

  tetris_drop_ctrl_if fb ();

  tetris_drop_ctrl #(.SPAWN_X(C_SX), .PIECE_COLOR(2'd3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .drop_tick (drop_tick),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .fb        (fb.master),
    .piece_x   (piece_x),
    .piece_y   (piece_y),
    .lines     (lines),
    .busy      (busy),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_acc = 0, n_wr = 0;
  int gnt_delay = 0;
  logic [31:0] mem [16];

  // abstract game model
  logic [1:0] g [16][16];
  int m_x, m_y, m_lines;
  bit m_over, m_active;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // framebuffer + arbiter model
  bit          s_busy = 1'b0;
  int          s_dly = 0, s_cnt = 0;
  logic        s_we;
  logic [3:0]  s_addr;
  logic [31:0] s_wdata;
  initial begin
    fb.fb_gnt   = 1'b0;
    fb.fb_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (fb.fb_gnt) begin
        fb.fb_gnt = 1'b0;
        n_acc++;
        if (s_we) begin
          mem[s_addr] = s_wdata;
          n_wr++;
        end else begin
          fb.fb_rdata = mem[s_addr];
        end
        chk_val("req_drop", 64'(fb.fb_req), 64'd0);
        s_busy = 1'b0;
      end else if (!rst_n || !fb.fb_req) begin
        s_busy = 1'b0;
      end else begin
        if (!s_busy) begin
          s_busy  = 1'b1;
          s_cnt   = 0;
          s_we    = fb.fb_we;
          s_addr  = fb.fb_addr;
          s_wdata = fb.fb_wdata;
          s_dly   = (gnt_delay < 0) ? int'($urandom_range(0, 3)) : gnt_delay;
        end else begin
          chk_val("req_hold", 64'({fb.fb_we, fb.fb_addr, fb.fb_wdata}),
                  64'({s_we, s_addr, s_wdata}));
        end
        if (s_cnt >= s_dly) fb.fb_gnt = 1'b1;
        else                s_cnt++;
      end
    end
  end

  function automatic logic [31:0] row_of(input int r);
    logic [31:0] v;
    v = 32'd0;
    for (int c = 0; c < 16; c++) v[2*c +: 2] = g[r][c];
    return v;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) g[r][c] = mem[r][2*c +: 2];
    m_x = int'(C_SX); m_y = 15; m_lines = 0; m_over = 1'b0; m_active = 1'b0;
  endtask

  task automatic m_spawn();
    if (g[15][C_SX] != 2'd0) begin
      m_over = 1'b1;
    end else begin
      g[15][C_SX] = 2'd3;
      m_x = int'(C_SX);
      m_y = 15;
      m_over = 1'b0;
    end
  endtask

  task automatic m_land();
`ifdef TETRIS_LINE_CLEAR_EN
    bit full;
    full = 1'b1;
    for (int c = 0; c < 16; c++) if (g[m_y][c] == 2'd0) full = 1'b0;
    if (full) begin
      for (int r = m_y; r < 15; r++)
        for (int c = 0; c < 16; c++) g[r][c] = g[r+1][c];
      for (int c = 0; c < 16; c++) g[15][c] = 2'd0;
      if (m_lines < 255) m_lines++;
    end
`endif
    m_spawn();
  endtask

  task automatic m_step(input bit t, input bit l, input bit r, input bit s);
    if (!m_active || m_over) begin
      if (s) begin
        if (m_over)
          for (int y = 0; y < 16; y++)
            for (int c = 0; c < 16; c++) g[y][c] = 2'd0;
        if (m_over) m_lines = 0;
        m_active = 1'b1;
        m_spawn();
      end
    end else if (t) begin
      if (m_y > 0 && g[m_y-1][m_x] == 2'd0) begin
        g[m_y][m_x] = 2'd0;
        g[m_y-1][m_x] = 2'd3;
        m_y--;
      end else begin
        m_land();
      end
    end else if (l && !r && m_x > 0) begin
      if (g[m_y][m_x-1] == 2'd0) begin
        g[m_y][m_x] = 2'd0; g[m_y][m_x-1] = 2'd3; m_x--;
      end
    end else if (r && !l && m_x < 15) begin
      if (g[m_y][m_x+1] == 2'd0) begin
        g[m_y][m_x] = 2'd0; g[m_y][m_x+1] = 2'd3; m_x++;
      end
    end
  endtask

  task automatic compare_all();
    chk_val("piece_x", 64'(piece_x), 64'(m_x));
    chk_val("piece_y", 64'(piece_y), 64'(m_y));
    chk_val("game_over", 64'(game_over), 64'(m_over));
    chk_val("lines", 64'(lines), 64'(m_lines));
    chk_val("busy_idle", 64'(busy), 64'd0);
    for (int r = 0; r < 16; r++)
      chk_val($sformatf("row%0d", r), 64'(mem[r]), 64'(row_of(r)));
  endtask

  // One input pulse, then wait for the DUT to settle; pulses injected while
  // busy must be discarded by the DUT, so the model never sees them.
  task automatic do_event(input bit t, input bit l, input bit r, input bit s);
    int n;
    drop_tick = t; btn_left = l; btn_right = r; start = s;
    @(posedge clk); #1;
    drop_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; start = 1'b0;
    n = 0;
    while (busy && n < 4000) begin
      if ($urandom_range(0, 3) == 0) begin
        drop_tick = 1'($urandom_range(0, 1));
        btn_left  = 1'($urandom_range(0, 1));
        btn_right = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      drop_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      n++;
    end
    chk_val("settle_timeout", 64'(n >= 4000), 64'd0);
    @(negedge clk); #1;
    m_step(t, l, r, s);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    m_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, a0, k;
    for (int r = 0; r < 16; r++) mem[r] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_req", 64'(fb.fb_req), 64'd0);
    chk_val("rst_we", 64'(fb.fb_we), 64'd0);
    chk_val("rst_addr", 64'(fb.fb_addr), 64'd0);
    chk_val("rst_wdata", 64'(fb.fb_wdata), 64'd0);
    chk_val("rst_x", 64'(piece_x), 64'(C_SX));
    chk_val("rst_y", 64'(piece_y), 64'd15);
    chk_val("rst_lines", 64'(lines), 64'd0);
    chk_val("rst_busy", 64'(busy), 64'd0);
    chk_val("rst_over", 64'(game_over), 64'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    m_reset();

    // spawn on empty board, zero-latency grants
    gnt_delay = 0;
    do_event(1'b0, 1'b0, 1'b0, 1'b1);
    chk_val("spawn_row15", 64'(mem[15]), 64'h300);
    for (int i = 0; i < 15; i++) do_event(1'b1, 1'b0, 1'b0, 1'b0);
    chk_val("floor_row0", 64'(mem[0]), 64'h300);
    chk_val("floor_y", 64'(piece_y), 64'd0);
    do_event(1'b1, 1'b0, 1'b0, 1'b0);
    chk_val("respawn_y", 64'(piece_y), 64'd15);

    // left wall, blocked right, tick beats button
    for (int i = 0; i < 4; i++) do_event(1'b0, 1'b1, 1'b0, 1'b0);
    w0 = n_wr;
    do_event(1'b0, 1'b1, 1'b0, 1'b0);
    chk_val("wall_nowr", 64'(n_wr - w0), 64'd0);
    chk_val("wall_x", 64'(piece_x), 64'd0);
    for (int i = 0; i < 4; i++) do_event(1'b0, 1'b0, 1'b1, 1'b0);
    mem[15][11:10] = 2'd3;
    g[15][5] = 2'd3;
    w0 = n_wr;
    do_event(1'b0, 1'b0, 1'b1, 1'b0);
    chk_val("block_nowr", 64'(n_wr - w0), 64'd0);
    chk_val("block_x", 64'(piece_x), 64'd4);
    do_event(1'b1, 1'b1, 1'b0, 1'b0);
    chk_val("tick_pri_x", 64'(piece_x), 64'd4);
    chk_val("tick_pri_y", 64'(piece_y), 64'd14);

    // landing into a nearly full floor row
    do_reset();
    for (int r = 0; r < 16; r++) mem[r] = 32'd0;
    mem[0] = 32'hFFFF_FCFF;
    mem[1] = 32'h0000_000C;
    m_reset();
    do_event(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) do_event(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef TETRIS_LINE_CLEAR_EN
    chk_val("clr_row0", 64'(mem[0]), 64'h0000_000C);
    chk_val("clr_lines", 64'(lines), 64'd1);
`else
    chk_val("clr_row0", 64'(mem[0]), 64'hFFFF_FFFF);
    chk_val("clr_lines", 64'(lines), 64'd0);
`endif

    // blocked spawn, then restart clears the board
    do_reset();
    for (int r = 0; r < 16; r++) mem[r] = 32'd0;
    mem[15] = 32'h300;
    m_reset();
    w0 = n_wr;
    do_event(1'b0, 1'b0, 1'b0, 1'b1);
    chk_val("over_flag", 64'(game_over), 64'd1);
    chk_val("over_nowr", 64'(n_wr - w0), 64'd0);
    w0 = n_wr;
    do_event(1'b0, 1'b0, 1'b0, 1'b1);
    chk_val("restart_wr", 64'(n_wr - w0), 64'd17);

    // random play with random grant latency
    gnt_delay = -1;
    for (int i = 0; i < 300; i++) begin
      if (!m_active || m_over) begin
        do_event(1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        k = int'($urandom_range(0, 9));
        case (k)
          5:       do_event(1'b0, 1'b1, 1'b0, 1'b0);
          6:       do_event(1'b0, 1'b0, 1'b1, 1'b0);
          7:       do_event(1'b0, 1'b1, 1'b1, 1'b0);
          8:       do_event(1'b1, 1'b1, 1'b0, 1'b0);
          9:       do_event(1'b1, 1'b0, 1'b1, 1'b0);
          default: do_event(1'b1, 1'b0, 1'b0, 1'b0);
        endcase
      end
    end

    // reset while a request waits on a slow grant
    gnt_delay = 7;
    do_reset();
    for (int r = 0; r < 16; r++) mem[r] = 32'd0;
    m_reset();
    do_event(1'b0, 1'b0, 1'b0, 1'b1);
    drop_tick = 1'b1;
    @(posedge clk); #1;
    drop_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("pre_rst_req", 64'(fb.fb_req), 64'd1);
    a0 = n_acc;
    #1 rst_n = 1'b0;
    #1;
    chk_val("async_req", 64'(fb.fb_req), 64'd0);
    chk_val("async_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk_val("post_rst_acc", 64'(n_acc - a0), 64'd0);
    chk_val("post_rst_req", 64'(fb.fb_req), 64'd0);
    chk_val("post_rst_over", 64'(game_over), 64'd0);
    chk_val("post_rst_y", 64'(piece_y), 64'd15);
    chk_val("post_rst_row15", 64'(mem[15]), 64'h300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
